// File: rtl/pa_spsram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM.
// Optional parity side array is enabled by defining PA_SPSRAM_PARITY_EN.
package pa_spsram_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Widest write group the parity helper accepts (zero padding keeps parity).
    localparam int PAR_MAXW = 1024;

    // Even-parity bit of one write group, zero-extended to PAR_MAXW.
    function automatic logic grp_parity(input logic [PAR_MAXW-1:0] v);
        return ^v;
    endfunction

    // Data must split evenly into write groups.
    function automatic bit widths_legal(input int dw, input int we);
        return (we > 0) && (dw >= we) && ((dw % we) == 0);
    endfunction

endpackage

// File: rtl/pa_spsram_param_if.sv
// Access bus of the parametrised single-port SRAM.
// PAR_INJ / par_err exist only when PA_SPSRAM_PARITY_EN is defined.
interface pa_spsram_param_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 45,
    parameter int WE_WIDTH   = 45
);
    import pa_spsram_pkg::*;

    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [WE_WIDTH-1:0]   WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  init_done;
`ifdef PA_SPSRAM_PARITY_EN
    logic                  PAR_INJ;
    logic                  par_err;

    modport master (
        output A, CEN, GWEN, WEN, D, PAR_INJ,
        input  Q, init_done, par_err
    );
    modport slave (
        input  A, CEN, GWEN, WEN, D, PAR_INJ,
        output Q, init_done, par_err
    );
`else
    modport master (
        output A, CEN, GWEN, WEN, D,
        input  Q, init_done
    );
    modport slave (
        input  A, CEN, GWEN, WEN, D,
        output Q, init_done
    );
`endif

endinterface

// File: rtl/pa_spsram_init_ctrl.sv
// Post-reset initialisation sweep: walks every entry once, then flags ready.
// Drives the array write-port select while the sweep is running.
module pa_spsram_init_ctrl
    import pa_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  cpurst_b,
    output logic                  init_we_o,
    output logic [ADDR_WIDTH-1:0] init_addr_o,
    output logic                  init_done_o
);
    localparam logic [ADDR_WIDTH-1:0] LAST   = '1;
    localparam state_e                RST_ST = INIT_EN ? ST_INIT : ST_READY;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    // State, sweep counter and registered ready flag.
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            state_q <= RST_ST;
            cnt_q   <= '0;
            done_q  <= !INIT_EN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Advance one entry per cycle; leave INIT on the cycle that writes the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                cnt_d = cnt_q;
            end
        endcase
        done_d = (state_d == ST_READY);
    end

    // Sweep owns the write port for as long as it is in INIT.
    always_comb begin
        init_we_o   = (state_q == ST_INIT);
        init_addr_o = cnt_q;
        init_done_o = done_q;
    end

endmodule

// File: rtl/pa_spsram_param.sv
// Parametrised single-port synchronous SRAM with grouped write mask and init sweep.
// Define PA_SPSRAM_PARITY_EN to add per-group even parity with error injection.
module pa_spsram_param
    import pa_spsram_pkg::*;
#(
    parameter int                        ADDR_WIDTH = 6,
    parameter int                        DATA_WIDTH = 45,
    parameter int                        WE_WIDTH   = 45,
    parameter bit                        INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0]     INIT_VAL   = '0
) (
    input  logic              CLK,
    input  logic              cpurst_b,
    pa_spsram_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int GW    = DATA_WIDTH / WE_WIDTH;

    if (!widths_legal(DATA_WIDTH, WE_WIDTH)) begin : g_bad_widths
        $error("pa_spsram_param: DATA_WIDTH must be a multiple of WE_WIDTH");
    end

    logic                  init_we;
    logic                  init_done;
    logic [ADDR_WIDTH-1:0] init_addr;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [WE_WIDTH-1:0]   wr_mask;
    logic                  rd_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] q_q, q_d;

    pa_spsram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_EN    (INIT_EN)
    ) u_init (
        .CLK         (CLK),
        .cpurst_b    (cpurst_b),
        .init_we_o   (init_we),
        .init_addr_o (init_addr),
        .init_done_o (init_done)
    );

    // Write-port mux: sweep first, user accesses only once the array is ready.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = bus.A;
        wr_data = bus.D;
        wr_mask = ~bus.WEN;
        if (cpurst_b && init_we) begin
            wr_en   = 1'b1;
            wr_addr = init_addr;
            wr_data = INIT_VAL;
            wr_mask = '1;
        end else if (cpurst_b && init_done && !bus.CEN) begin
            wr_en = !bus.GWEN;
            rd_en = bus.GWEN;
        end
    end

    // Array update, merging only the enabled write groups; never reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int g = 0; g < WE_WIDTH; g++) begin
                if (wr_mask[g]) begin
                    mem_q[wr_addr][g*GW +: GW] <= wr_data[g*GW +: GW];
                end
            end
        end
    end

    // Read data is captured on reads only and otherwise held.
    always_comb begin
        q_d = rd_en ? mem_q[bus.A] : q_q;
    end

    // Registered read output.
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.init_done = init_done;

`ifdef PA_SPSRAM_PARITY_EN
    logic [WE_WIDTH-1:0] par_mem_q [DEPTH];
    logic [WE_WIDTH-1:0] wr_par;
    logic [WE_WIDTH-1:0] rd_par;
    logic                wr_inj;
    logic                perr_q, perr_d;

    for (genvar g = 0; g < WE_WIDTH; g++) begin : g_par
        assign wr_par[g] = grp_parity({{(PAR_MAXW-GW){1'b0}}, wr_data[g*GW +: GW]});
        assign rd_par[g] = grp_parity({{(PAR_MAXW-GW){1'b0}}, mem_q[bus.A][g*GW +: GW]});
    end

    assign wr_inj = !init_we && bus.PAR_INJ;

    // Parity side array follows every group write, optionally inverted.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            for (int g = 0; g < WE_WIDTH; g++) begin
                if (wr_mask[g]) begin
                    par_mem_q[wr_addr][g] <= wr_par[g] ^ wr_inj;
                end
            end
        end
    end

    // Parity check result is refreshed together with Q on each read.
    always_comb begin
        perr_d = rd_en ? |(rd_par ^ par_mem_q[bus.A]) : perr_q;
    end

    // Registered parity error flag.
    always_ff @(posedge CLK) begin
        if (!cpurst_b) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.par_err = perr_q;
`endif

endmodule
